// File: rtl/prga_fifo_ext_pkg.sv
// Shared definitions for the prga_fifo_ext FIFO: lookahead mode codes,
// pointer-width derivation and the packed status-flag record.
package prga_fifo_ext_pkg;

    // LOOKAHEAD parameter values
    localparam int LA_STD  = 0;  // dout registered, one cycle after an accepted rd
    localparam int LA_FWFT = 1;  // first-word-fall-through, head visible while !empty

    // Pointers carry one extra wrap bit above the storage index
    function automatic int ptr_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    // Registered occupancy flags, all derived from the same next-state count
    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/prga_fifo_ext_if.sv
// Producer/consumer bundle for prga_fifo_ext.
// Handshake: a write is accepted on a rising edge where wr=1 and the registered
// full=0; a read is accepted on a rising edge where rd=1 and the registered
// empty=0. Requests against full/empty are dropped and raise the sticky errors.
interface prga_fifo_ext_if
    import prga_fifo_ext_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
);
    localparam int PW = ptr_width(DEPTH_LOG2);

    logic                  wr;
    logic [DATA_WIDTH-1:0] din;
    logic                  full;
    logic                  almost_full;
    logic                  rd;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic                  almost_empty;
    logic [PW-1:0]         count;
    logic                  err_overflow;
    logic                  err_underflow;
    logic                  err_clr;

    // Producer/consumer side
    modport master (
        output wr, din, rd, err_clr,
        input  full, almost_full, dout, empty, almost_empty, count,
               err_overflow, err_underflow
    );

    // FIFO side
    modport slave (
        input  wr, din, rd, err_clr,
        output full, almost_full, dout, empty, almost_empty, count,
               err_overflow, err_underflow
    );
endinterface

// File: rtl/prga_fifo_ext_ram.sv
// 1-read/1-write storage for prga_fifo_ext: synchronous write, asynchronous
// read so the lookahead path can present the head entry combinationally.
// Contents are deliberately not reset.
module prga_fifo_ext_ram
    import prga_fifo_ext_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [1 << DEPTH_LOG2];

    // Store the write data at the write index on an accepted write
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/prga_fifo_ext.sv
// prga_fifo_ext: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// errors and either first-word-fall-through or registered read data.
module prga_fifo_ext
    import prga_fifo_ext_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int LOOKAHEAD  = 0,
    parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    prga_fifo_ext_if.slave   fifo_if
);
    localparam int            PW     = ptr_width(DEPTH_LOG2);
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q, count_d;
    fifo_flags_t           flags_q, flags_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_unf_q, err_unf_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  wr_ok, rd_ok;

    // Acceptance is gated by the registered flags only
    assign wr_ok = fifo_if.wr && !flags_q.full;
    assign rd_ok = fifo_if.rd && !flags_q.empty;

    prga_fifo_ext_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i (wr_ptr_q[PW-2:0]),
        .wdata_i (fifo_if.din),
        .raddr_i (rd_ptr_q[PW-2:0]),
        .rdata_o (ram_rdata)
    );

    // Next pointers, occupancy and flags; wrap is plain binary overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, wr_ok};
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, rd_ok};
        count_d  = wr_ptr_d - rd_ptr_d;
        flags_d.empty        = (wr_ptr_d == rd_ptr_d);
        flags_d.full         = (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]) &&
                               (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]);
        flags_d.almost_full  = (count_d >= AF_LVL);
        flags_d.almost_empty = (count_d <= AE_LVL);
    end

    // Sticky errors: a coincident error event beats err_clr
    always_comb begin
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        if (fifo_if.err_clr) begin
            err_ovf_d = 1'b0;
            err_unf_d = 1'b0;
        end
        if (fifo_if.wr && flags_q.full) begin
            err_ovf_d = 1'b1;
        end
        if (fifo_if.rd && flags_q.empty) begin
            err_unf_d = 1'b1;
        end
    end

    // Read data register: tracks the head in FWFT mode (so it holds the last
    // head once empty), or loads on each accepted read in standard mode
    always_comb begin
        dout_d = dout_q;
        if (LOOKAHEAD == LA_FWFT) begin
            if (!flags_q.empty) begin
                dout_d = ram_rdata;
            end
        end else if (rd_ok) begin
            dout_d = ram_rdata;
        end
    end

    // State registers; reset discards contents but leaves storage untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            flags_q   <= '{full: 1'b0, almost_full: 1'b0, empty: 1'b1, almost_empty: 1'b1};
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            flags_q   <= flags_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
            dout_q    <= dout_d;
        end
    end

    assign fifo_if.full          = flags_q.full;
    assign fifo_if.almost_full   = flags_q.almost_full;
    assign fifo_if.empty         = flags_q.empty;
    assign fifo_if.almost_empty  = flags_q.almost_empty;
    assign fifo_if.count         = count_q;
    assign fifo_if.err_overflow  = err_ovf_q;
    assign fifo_if.err_underflow = err_unf_q;
    assign fifo_if.dout          = ((LOOKAHEAD == LA_FWFT) && !flags_q.empty) ? ram_rdata : dout_q;
endmodule

// File: tb/tb_prga_fifo_ext.sv
// Directed bench for prga_fifo_ext: a FWFT instance and a standard instance,
// both DEPTH=4, driven with identical stimulus.
module tb_prga_fifo_ext;
    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;
    logic [7:0] exp_q[$];

    prga_fifo_ext_if #(.DATA_WIDTH(8), .DEPTH_LOG2(2)) if_la ();
    prga_fifo_ext_if #(.DATA_WIDTH(8), .DEPTH_LOG2(2)) if_std ();

    prga_fifo_ext #(
        .DATA_WIDTH(8), .DEPTH_LOG2(2), .LOOKAHEAD(1), .AF_THRESH(3), .AE_THRESH(1)
    ) dut_la (
        .clk(clk), .rst_n(rst_n), .fifo_if(if_la)
    );

    prga_fifo_ext #(
        .DATA_WIDTH(8), .DEPTH_LOG2(2), .LOOKAHEAD(0)
    ) dut_std (
        .clk(clk), .rst_n(rst_n), .fifo_if(if_std)
    );

    // {full, almost_full, empty, almost_empty, count[2:0], err_overflow, err_underflow}
    logic [8:0] st_la, st_std;
    assign st_la  = {if_la.full, if_la.almost_full, if_la.empty, if_la.almost_empty,
                     if_la.count, if_la.err_overflow, if_la.err_underflow};
    assign st_std = {if_std.full, if_std.almost_full, if_std.empty, if_std.almost_empty,
                     if_std.count, if_std.err_overflow, if_std.err_underflow};

    // Expected status for DEPTH=4, almost_full at >=3, almost_empty at <=1
    function automatic logic [8:0] exp_st(input int c, input logic o, input logic u);
        return {(c == 4), (c >= 3), (c == 0), (c <= 1), 3'(c), o, u};
    endfunction

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
        if_la.wr  = w;  if_la.din  = d;  if_la.rd  = r;  if_la.err_clr  = c;
        if_std.wr = w;  if_std.din = d;  if_std.rd = r;  if_std.err_clr = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        tick();
        tick();
        n_run++;
        if ({st_la, st_std} !== {exp_st(0, 0, 0), exp_st(0, 0, 0)}) begin
            n_fail++;
            $display("FAIL reset_status: got %b/%b want %b", st_la, st_std, exp_st(0, 0, 0));
        end
        n_run++;
        if ({if_la.dout, if_std.dout} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_dout: got %h/%h want 00", if_la.dout, if_std.dout);
        end
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        n_run++;
        if ({st_la, st_std} !== {exp_st(0, 0, 0), exp_st(0, 0, 0)}) begin
            n_fail++;
            $display("FAIL reset_no_write: got %b/%b want %b", st_la, st_std, exp_st(0, 0, 0));
        end
    endtask

    task automatic test_lookahead();
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        tick();
        n_run++;
        if (if_la.dout !== 8'hA1 || st_la !== exp_st(1, 0, 0)) begin
            n_fail++;
            $display("FAIL la_first: got dout %h st %b want A1 %b", if_la.dout, st_la, exp_st(1, 0, 0));
        end
        drive(1'b1, 8'hA2, 1'b0, 1'b0);
        tick();
        n_run++;
        if (if_la.dout !== 8'hA1 || st_std !== exp_st(2, 0, 0)) begin
            n_fail++;
            $display("FAIL la_hold_head: got dout %h st %b want A1 %b", if_la.dout, st_std, exp_st(2, 0, 0));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        n_run++;
        if ({if_la.dout, if_std.dout} !== 16'hA2A1 || st_la !== exp_st(1, 0, 0)) begin
            n_fail++;
            $display("FAIL la_pop: got la %h std %h want A2 A1", if_la.dout, if_std.dout);
        end
        tick();
        n_run++;
        if (if_std.dout !== 8'hA2 || st_std !== exp_st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL la_drain: got std %h st %b want A2 %b", if_std.dout, st_std, exp_st(0, 0, 0));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_standard();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_run++;
        if (st_std !== exp_st(4, 0, 0) || if_std.dout !== 8'hA2 || if_la.dout !== 8'h11) begin
            n_fail++;
            $display("FAIL std_filled: got st %b std %h la %h want %b A2 11",
                     st_std, if_std.dout, if_la.dout, exp_st(4, 0, 0));
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
            n_run++;
            if (if_std.dout !== 8'(8'h11 + i) || st_std !== exp_st(3 - i, 0, 0)) begin
                n_fail++;
                $display("FAIL std_read%0d: got %h st %b want %h %b", i, if_std.dout, st_std,
                         8'(8'h11 + i), exp_st(3 - i, 0, 0));
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        tick();
        n_run++;
        if ({st_la, st_std} !== {exp_st(4, 1, 0), exp_st(4, 1, 0)}) begin
            n_fail++;
            $display("FAIL ovf_set: got %b/%b want %b", st_la, st_std, exp_st(4, 1, 0));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        n_run++;
        if (st_std !== exp_st(4, 1, 0)) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b want %b", st_std, exp_st(4, 1, 0));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        n_run++;
        if (st_std !== exp_st(4, 0, 0)) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b want %b", st_std, exp_st(4, 0, 0));
        end
        drive(1'b1, 8'hFF, 1'b0, 1'b1);
        tick();
        n_run++;
        if (st_la !== exp_st(4, 1, 0)) begin
            n_fail++;
            $display("FAIL ovf_event_wins: got %b want %b", st_la, exp_st(4, 1, 0));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
            n_run++;
            if (if_std.dout !== 8'(8'h21 + i)) begin
                n_fail++;
                $display("FAIL ovf_read%0d: got %h want %h", i, if_std.dout, 8'(8'h21 + i));
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_run++;
        if (st_std !== exp_st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL ovf_drained: got %b want %b", st_std, exp_st(0, 0, 0));
        end
    endtask

    task automatic test_underflow();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        n_run++;
        if ({st_la, st_std} !== {exp_st(0, 0, 1), exp_st(0, 0, 1)} || if_std.dout !== 8'h24) begin
            n_fail++;
            $display("FAIL unf_set: got %b/%b dout %h want %b 24", st_la, st_std, if_std.dout, exp_st(0, 0, 1));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        n_run++;
        if (st_std !== exp_st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL unf_clear: got %b want %b", st_std, exp_st(0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 8'h31, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h32, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h33, 1'b1, 1'b0);
        tick();
        n_run++;
        if (st_std !== exp_st(2, 0, 0) || if_std.dout !== 8'h31 || if_la.dout !== 8'h32) begin
            n_fail++;
            $display("FAIL simul_wr_rd: got st %b std %h la %h want %b 31 32",
                     st_std, if_std.dout, if_la.dout, exp_st(2, 0, 0));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        tick();
        n_run++;
        if (if_std.dout !== 8'h33 || st_std !== exp_st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL simul_order: got %h st %b want 33 %b", if_std.dout, st_std, exp_st(0, 0, 0));
        end
        // rd on full frees a slot only on the next cycle, so the paired wr overflows
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'h45, 1'b1, 1'b0);
        tick();
        n_run++;
        if (st_std !== exp_st(3, 1, 0) || if_std.dout !== 8'h41) begin
            n_fail++;
            $display("FAIL full_wr_rd: got st %b dout %h want %b 41", st_std, if_std.dout, exp_st(3, 1, 0));
        end
        drive(1'b1, 8'h46, 1'b0, 1'b1);
        tick();
        n_run++;
        if (st_la !== exp_st(4, 0, 0)) begin
            n_fail++;
            $display("FAIL refill: got %b want %b", st_la, exp_st(4, 0, 0));
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_run++;
        if (if_std.dout !== 8'h46 || st_std !== exp_st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL refill_drain: got %h st %b want 46 %b", if_std.dout, st_std, exp_st(0, 0, 0));
        end
    endtask

    task automatic test_wrap();
        logic [1:0] ops [28];
        logic [7:0] nxt;
        logic [7:0] popped;
        logic       w, r, w_ok, r_ok, ovf_m, unf_m;
        ops = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11,
                2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01,
                2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        nxt    = 8'h50;
        popped = 8'h00;
        ovf_m  = 1'b0;
        unf_m  = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 28; i++) begin
            w    = ops[i][1];
            r    = ops[i][0];
            w_ok = w && (exp_q.size() < 4);
            r_ok = r && (exp_q.size() > 0);
            ovf_m = ovf_m | (w && !w_ok);
            unf_m = unf_m | (r && !r_ok);
            drive(w, nxt, r, 1'b0);
            if (r_ok) popped = exp_q.pop_front();
            if (w_ok) begin
                exp_q.push_back(nxt);
                nxt = nxt + 8'h01;
            end
            tick();
            n_run++;
            if ({st_la, st_std} !== {exp_st(exp_q.size(), ovf_m, unf_m), exp_st(exp_q.size(), ovf_m, unf_m)} ||
                (r_ok && if_std.dout !== popped) ||
                (exp_q.size() > 0 && if_la.dout !== exp_q[0])) begin
                n_fail++;
                $display("FAIL wrap_step%0d: got st %b/%b std %h la %h want st %b std %h la %h",
                         i, st_la, st_std, if_std.dout, if_la.dout,
                         exp_st(exp_q.size(), ovf_m, unf_m), popped,
                         (exp_q.size() > 0) ? exp_q[0] : 8'h00);
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h71, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h72, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 8'h7F, 1'b1, 1'b0);
        tick();
        n_run++;
        if ({st_la, st_std} !== {exp_st(0, 0, 0), exp_st(0, 0, 0)} || if_std.dout !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: got %b/%b dout %h want %b 00", st_la, st_std, if_std.dout, exp_st(0, 0, 0));
        end
        rst_n = 1'b1;
        drive(1'b1, 8'h61, 1'b0, 1'b0);
        tick();
        n_run++;
        if (if_la.dout !== 8'h61 || st_la !== exp_st(1, 0, 0)) begin
            n_fail++;
            $display("FAIL mid_reset_write: got %h st %b want 61 %b", if_la.dout, st_la, exp_st(1, 0, 0));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        n_run++;
        if (if_std.dout !== 8'h61 || st_std !== exp_st(0, 0, 0)) begin
            n_fail++;
            $display("FAIL mid_reset_read: got %h st %b want 61 %b", if_std.dout, st_std, exp_st(0, 0, 0));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_lookahead();
        test_standard();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
